// File: rtl/game_input_conditioner.sv
// game_input_conditioner: synchronises, debounces and edge-detects the breakout buttons,
// adds hold-to-repeat on left/right and latches each event as a sticky request.
module game_input_conditioner #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int DEBOUNCE_N   = 10,
  parameter int REPEAT_DELAY = 300,
  parameter int REPEAT_RATE  = 100
) (
  input  logic CLK,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic throw_raw,
  input  logic consume,
  output logic left_req,
  output logic right_req,
  output logic throw_req,
  output logic left_held,
  output logic right_held,
  output logic throw_held,
  output logic sample_tick
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DB_W = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_N - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

  logic [DIV_W-1:0] r_div;
  logic w_tick;
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_stable;
  logic [2:0] w_flip;
  logic [2:0] w_stable_nxt;
  logic [2:0] w_ev;
  logic [2:0] r_req;
  logic [1:0] w_rpt_ev;
  logic w_conflict;

  assign w_raw = {throw_raw, right_raw, left_raw};
  assign w_tick = r_div == DIV_LAST;

  always_ff @(posedge CLK) begin
    if (reset) r_div <= '0;
    else r_div <= w_tick ? '0 : r_div + DIV_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_stable <= '0;
      r_req <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_stable <= w_stable_nxt;
      r_req <= w_ev | (r_req & ~{3{consume}});
    end
  end

  // A level change is accepted on the DEBOUNCE_N-th consecutive differing sample.
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DB_W-1:0] r_cnt;
    logic w_diff;
    assign w_diff = r_sync2[i] ^ r_stable[i];
    assign w_flip[i] = w_tick & w_diff & (r_cnt == DB_LAST);
    always_ff @(posedge CLK) begin
      if (reset) r_cnt <= '0;
      else if (w_tick) r_cnt <= (w_diff && !w_flip[i]) ? r_cnt + DB_W'(1) : '0;
    end
  end

  assign w_stable_nxt = r_stable ^ w_flip;

  for (genvar i = 0; i < 2; i++) begin : g_rpt
    rpt_state_t r_state;
    rpt_state_t w_state_nxt;
    logic [RPT_W-1:0] r_cnt;
    logic [RPT_W-1:0] w_cnt_nxt;
    logic w_fire;
    logic w_rise;
    logic w_fall;
    assign w_rise = w_flip[i] & ~r_stable[i];
    assign w_fall = w_flip[i] & r_stable[i];
    always_ff @(posedge CLK) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_cnt <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt = r_cnt;
      w_fire = 1'b0;
      if (w_fall) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_fire = w_rise;
            w_cnt_nxt = '0;
            w_state_nxt = w_rise ? ST_DELAY : ST_IDLE;
          end
          ST_DELAY: if (w_tick) begin
            w_fire = r_cnt == DELAY_LAST;
            w_cnt_nxt = w_fire ? '0 : r_cnt + RPT_W'(1);
            w_state_nxt = w_fire ? ST_REPEAT : ST_DELAY;
          end
          ST_REPEAT: if (w_tick) begin
            w_fire = r_cnt == RATE_LAST;
            w_cnt_nxt = w_fire ? '0 : r_cnt + RPT_W'(1);
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
    assign w_rpt_ev[i] = w_fire;
  end

  // Judged on the post-edge levels, so the press that creates the conflict is itself suppressed.
  assign w_conflict = w_stable_nxt[0] & w_stable_nxt[1];
  assign w_ev = {w_flip[2] & ~r_stable[2], w_rpt_ev & {2{~w_conflict}}};

  assign left_req = r_req[0];
  assign right_req = r_req[1];
  assign throw_req = r_req[2];
  assign left_held = r_stable[0];
  assign right_held = r_stable[1];
  assign throw_held = r_stable[2];
  assign sample_tick = w_tick;
endmodule

// File: tb/tb_game_input_conditioner.sv
// tb_game_input_conditioner: randomized and directed stimulus against a tick-level
// reference model; expected output vectors are queued per clock and popped by a monitor.
module tb_game_input_conditioner;
  localparam int SD = 4;
  localparam int DN = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic left_raw = 1'b0;
  logic right_raw = 1'b0;
  logic throw_raw = 1'b0;
  logic consume = 1'b0;
  logic left_req, right_req, throw_req, left_held, right_held, throw_held, sample_tick;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [6:0] exp_q[$];

  game_input_conditioner #(
    .SAMPLE_DIV(SD), .DEBOUNCE_N(DN), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLK(CLK), .reset(reset),
    .left_raw(left_raw), .right_raw(right_raw), .throw_raw(throw_raw),
    .consume(consume),
    .left_req(left_req), .right_req(right_req), .throw_req(throw_req),
    .left_held(left_held), .right_held(right_held), .throw_held(throw_held),
    .sample_tick(sample_tick)
  );

  always #5 CLK = ~CLK;

  // Reference model: inputs seen two clocks late, N differing samples flip a level,
  // events at press and at held-tick counts RD, RD+RR, RD+2RR, ...
  initial begin : model
    bit sy1[3], sy2[3], st[3], rq[3], ev[3], raw[3];
    bit tk, flip;
    int dc[3], ht[3];
    int k;
    k = 0;
    forever begin
      @(posedge CLK);
      raw[0] = left_raw;
      raw[1] = right_raw;
      raw[2] = throw_raw;
      if (reset) begin
        k = 0;
        for (int b = 0; b < 3; b++) begin
          sy1[b] = 0; sy2[b] = 0; st[b] = 0; rq[b] = 0; dc[b] = 0; ht[b] = 0;
        end
      end else begin
        tk = (k % SD) == SD - 1;
        k++;
        for (int b = 0; b < 3; b++) begin
          ev[b] = 0;
          if (tk) begin
            if (sy2[b] != st[b]) dc[b]++;
            else dc[b] = 0;
            flip = dc[b] == DN;
            if (flip) begin
              st[b] = !st[b];
              dc[b] = 0;
              ev[b] = st[b];
              ht[b] = 0;
            end else if (st[b]) begin
              ht[b]++;
              ev[b] = (b < 2) && (ht[b] == RD || (ht[b] > RD && (ht[b] - RD) % RR == 0));
            end
          end
          sy2[b] = sy1[b];
          sy1[b] = raw[b];
        end
        if (st[0] && st[1]) begin
          ev[0] = 0;
          ev[1] = 0;
        end
        for (int b = 0; b < 3; b++) rq[b] = ev[b] || (rq[b] && !consume);
      end
      exp_q.push_back({st[2], st[1], st[0], rq[2], rq[1], rq[0], (k % SD) == SD - 1});
    end
  end

  initial begin : monitor
    logic [6:0] e, g;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {throw_held, right_held, left_held, throw_req, right_req, left_req, sample_tick};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got(th,rh,lh,tq,rq,lq,tick)=%b expected=%b", $time, g, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  // mode: 0 idle, 1 consume every pending request, 2 random consume, 3 hold consume high
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      consume = (mode == 1) ? (left_req | right_req | throw_req) :
                (mode == 2) ? ($urandom_range(0, 5) == 0) : (mode == 3);
    end
  endtask

  initial begin : stim
    int w, seen, rises;
    logic pl, pr;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    chk("reset_outputs", {left_req, right_req, throw_req, left_held, right_held, throw_held, sample_tick}, 0);
    for (int c = 2; c <= 20; c++) begin
      @(negedge CLK);
      chk("tick_phase", sample_tick, (c % 4) == 0);
    end
    for (int i = 0; i < 8; i++) begin
      throw_raw = ~throw_raw;
      cyc(5);
    end
    chk("bounce_held", throw_held, 0);
    chk("bounce_req", throw_req, 0);
    throw_raw = 1'b1;
    cyc(18);
    chk("settle_held", throw_held, 1);
    chk("settle_req", throw_req, 1);
    consume = 1'b1;
    cyc(1);
    chk("consume_clears", throw_req, 0);
    throw_raw = 1'b0;
    cyc(6 * SD);
    mode = 1;
    left_raw = 1'b1;
    cyc(60 * SD);
    left_raw = 1'b0;
    cyc(6 * SD);
    chk("release_held", left_held, 0);
    mode = 0;
    left_raw = 1'b1;
    cyc(12 * SD);
    chk("coalesce_req", left_req, 1);
    mode = 3;
    consume = 1'b1;
    cyc(1);
    seen = 0;
    repeat (3 * SD) begin
      cyc(1);
      if (left_req) seen++;
    end
    chk("collision_event_wins", seen > 0, 1);
    mode = 0;
    left_raw = 1'b0;
    cyc(6 * SD);
    mode = 1;
    left_raw = 1'b1;
    w = 0;
    while (!left_held && w < 40 * SD) begin
      cyc(1);
      w++;
    end
    chk("left_accept", left_held, 1);
    cyc(SD);
    right_raw = 1'b1;
    rises = 0;
    pl = left_req;
    pr = right_req;
    repeat (12 * SD) begin
      cyc(1);
      if (left_held && right_held && ((left_req && !pl) || (right_req && !pr))) rises++;
      pl = left_req;
      pr = right_req;
    end
    chk("conflict_events", rises, 0);
    right_raw = 1'b0;
    cyc(12 * SD);
    left_raw = 1'b0;
    cyc(6 * SD);
    mode = 0;
    left_raw = 1'b1;
    cyc(12 * SD);
    chk("pre_reset_req", left_req, 1);
    reset = 1'b1;
    cyc(1);
    chk("mid_reset_clear", {left_req, right_req, throw_req, left_held, right_held, throw_held, sample_tick}, 0);
    reset = 1'b0;
    cyc(8);
    chk("post_reset_debouncing", left_held, 0);
    cyc(8);
    chk("post_reset_held", left_held, 1);
    chk("post_reset_req", left_req, 1);
    left_raw = 1'b0;
    cyc(6 * SD);
    mode = 2;
    repeat (1500) begin
      if ($urandom_range(0, 23) == 0) left_raw = ~left_raw;
      if ($urandom_range(0, 23) == 0) right_raw = ~right_raw;
      if ($urandom_range(0, 23) == 0) throw_raw = ~throw_raw;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      cyc(1);
    end
    mode = 0;
    repeat (2) @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
